ls_stream_sel_sequencer: RTL and testbench
==========================================

Name: ls_stream_sel_sequencer

Overview:
- Parametrised successor to the combinational load/store stream-select lookup.
- Holds a writable kernel-memory table of load and store stream selects per bank group and bank.
- An internal sequencer steps the table address on a step handshake, with a loop count.
- Drives registered select vectors to the load/store crossbar muxes, plus busy/done status to the PEA controller.

Parameters:
N_GROUPS, 4, number of bank groups
N_BANKS, 4, banks per stream group
KMEM_DEPTH, 8, table entries per bank (configuration steps)
L_SEL_W, 2, load-select width per bank (log2 of AGEs per stream)
S_SEL_W, 2, store-select width per bank (log2 of PEs per group)
ITER_W, 8, loop-counter width
Derived: ADDR_W = max(1, $clog2(KMEM_DEPTH)); GW = max(1, $clog2(N_GROUPS)); BW = max(1, $clog2(N_BANKS))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cfg_we_i  in  1  table write strobe
cfg_group_i  in  GW  write group index
cfg_bank_i  in  BW  write bank index
cfg_addr_i  in  ADDR_W  write entry index
cfg_l_sel_i  in  L_SEL_W  load select to write
cfg_s_sel_i  in  S_SEL_W  store select to write
cfg_err_o  out  1  one-cycle pulse: write rejected
start_i  in  1  start sequence
abort_i  in  1  abort sequence
n_last_i  in  ADDR_W  last entry index, sampled on start
n_iter_i  in  ITER_W  iteration count, sampled on start (0 is treated as 1)
step_i  in  1  advance to next entry
busy_o  out  1  sequencer in RUN
done_o  out  1  one-cycle pulse: sequence completed
cur_addr_o  out  ADDR_W  current entry index
l_stream_sel_o  out  N_GROUPS*N_BANKS*L_SEL_W  load selects, group-major then bank
s_stream_sel_o  out  N_GROUPS*N_BANKS*S_SEL_W  store selects, group-major then bank

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; table cleared to 0; state IDLE; counters 0. Reset mid-run aborts immediately; no done_o.
- Table write, effective at the next clock edge:
  - Accepted when cfg_we_i=1, cfg_group_i<N_GROUPS, cfg_bank_i<N_BANKS, cfg_addr_i<KMEM_DEPTH, and the write is allowed by state.
  - Any rejected write gives cfg_err_o=1 for one cycle and leaves the table unchanged.
- IDLE:
  - busy_o=0, cur_addr_o=0, select outputs 0.
  - start_i=1 captures n_last (clamped to KMEM_DEPTH-1) and n_iter, sets addr=0 and iter=0, enters RUN.
  - Select outputs equal entry 0 on the same edge (zero added latency; outputs registered).
  - step_i is ignored in IDLE.
- RUN:
  - busy_o=1; start_i ignored.
  - step_i with addr<n_last: addr+1; selects load the new entry on the same edge.
  - step_i with addr==n_last and iter<n_iter-1: addr wraps to 0, iter+1.
  - step_i with addr==n_last and iter==n_iter-1: return to IDLE; done_o=1 for one cycle; outputs return to 0.
  - abort_i: return to IDLE next edge, no done_o. abort_i has priority over step_i and start_i.
- Selects always reflect the table contents at the moment the entry was loaded. A write to the currently displayed entry is not visible until that entry is reloaded.
- Base build: writes during RUN are rejected (cfg_err_o).
- Simultaneous start_i and abort_i in IDLE: stay IDLE.
- n_last_i=0: every step_i counts as one iteration.

Optional Feature:
STREAM_SEL_SHADOW_EN
- Defined:
  - The table is duplicated into an active bank and a shadow bank.
  - cfg writes always target the shadow bank and are accepted in RUN.
  - The shadow is copied to the active bank on the edge that enters RUN from start_i, and on reset both banks clear.
  - The sequencer reads only the active bank.
- Undefined:
  - Single table.
  - Writes accepted only in IDLE and become active immediately.

Test Plan:
- Reset mid-RUN at addr=3 -> next cycle busy_o=0, cur_addr_o=0, selects 0, done_o never asserted.
- Write group1/bank2 entry0 l=3,s=1, then entry1 l=2,s=0; start with n_last=1, n_iter=1 -> l_stream_sel_o slice[1][2]=3 on the start edge, =2 after the first step_i; done_o after the second step_i.
- Start with n_last=2, n_iter=3; 9 step_i pulses -> cur_addr_o sequence 0,1,2,0,1,2,0,1,2; done_o exactly on the 9th; n_iter=0 -> done after 3 steps.
- Write with cfg_addr_i=KMEM_DEPTH, and a write during RUN (base build) -> cfg_err_o single pulse, table unchanged.
- abort_i together with step_i at addr=1 -> IDLE, no done_o; start_i together with abort_i in IDLE -> stays IDLE.
- With STREAM_SEL_SHADOW_EN: write entry0 during RUN -> no cfg_err_o, outputs unchanged; next start shows the new value.

Source files
------------

// File: rtl/ls_stream_sel_sequencer.sv
// Kernel-memory table of load/store stream selects with a step-driven address sequencer; select outputs registered.
// Latency: selects reflect the newly addressed entry on the same edge as start/step; no backpressure (step is a pulse).
// Optional STREAM_SEL_SHADOW_EN: shadow table takes writes in RUN, copied to the active table on start.
module ls_stream_sel_sequencer #(
    parameter int N_GROUPS   = 4,
    parameter int N_BANKS    = 4,
    parameter int KMEM_DEPTH = 8,
    parameter int L_SEL_W    = 2,
    parameter int S_SEL_W    = 2,
    parameter int ITER_W     = 8,
    parameter int ADDR_W     = (KMEM_DEPTH > 1) ? $clog2(KMEM_DEPTH) : 1,
    parameter int GW         = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    parameter int BW         = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_we_i,
    input  logic [GW-1:0]                       cfg_group_i,
    input  logic [BW-1:0]                       cfg_bank_i,
    input  logic [ADDR_W-1:0]                   cfg_addr_i,
    input  logic [L_SEL_W-1:0]                  cfg_l_sel_i,
    input  logic [S_SEL_W-1:0]                  cfg_s_sel_i,
    output logic                                cfg_err_o,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [ADDR_W-1:0]                   n_last_i,
    input  logic [ITER_W-1:0]                   n_iter_i,
    input  logic                                step_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [ADDR_W-1:0]                   cur_addr_o,
    output logic [N_GROUPS*N_BANKS*L_SEL_W-1:0] l_stream_sel_o,
    output logic [N_GROUPS*N_BANKS*S_SEL_W-1:0] s_stream_sel_o
);
    localparam int NL = N_GROUPS * N_BANKS * L_SEL_W;
    localparam int NS = N_GROUPS * N_BANKS * S_SEL_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr, n_last;
    logic [ITER_W-1:0]   iter, n_iter_m1;
    logic [ADDR_W-1:0]   rd_addr, n_last_c;
    logic [NL-1:0]       rd_l;
    logic [NS-1:0]       rd_s;
    logic                in_range, wr_ok, start_fire;

    logic [L_SEL_W-1:0]  act_l [N_GROUPS][N_BANKS][KMEM_DEPTH];
    logic [S_SEL_W-1:0]  act_s [N_GROUPS][N_BANKS][KMEM_DEPTH];
`ifdef STREAM_SEL_SHADOW_EN
    logic [L_SEL_W-1:0]  sh_l  [N_GROUPS][N_BANKS][KMEM_DEPTH];
    logic [S_SEL_W-1:0]  sh_s  [N_GROUPS][N_BANKS][KMEM_DEPTH];
`endif

    assign in_range   = (int'(cfg_group_i) < N_GROUPS) && (int'(cfg_bank_i) < N_BANKS) &&
                        (int'(cfg_addr_i) < KMEM_DEPTH);
`ifdef STREAM_SEL_SHADOW_EN
    assign wr_ok      = cfg_we_i && in_range;
`else
    assign wr_ok      = cfg_we_i && in_range && (state == IDLE);
`endif
    assign start_fire = (state == IDLE) && start_i && !abort_i;
    assign n_last_c   = (int'(n_last_i) > KMEM_DEPTH - 1) ? ADDR_W'(KMEM_DEPTH - 1) : n_last_i;

    // Entry that the next start/step edge will display; wraps to 0 after n_last.
    always_comb begin
        rd_addr = '0;
        if (state == RUN && addr != n_last)
            rd_addr = addr + ADDR_W'(1);
        rd_l = '0;
        rd_s = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int b = 0; b < N_BANKS; b++) begin
`ifdef STREAM_SEL_SHADOW_EN
                // On the start edge the active copy is not yet updated, so read the shadow directly.
                rd_l[(g*N_BANKS+b)*L_SEL_W +: L_SEL_W] = (state == IDLE) ? sh_l[g][b][rd_addr] : act_l[g][b][rd_addr];
                rd_s[(g*N_BANKS+b)*S_SEL_W +: S_SEL_W] = (state == IDLE) ? sh_s[g][b][rd_addr] : act_s[g][b][rd_addr];
`else
                rd_l[(g*N_BANKS+b)*L_SEL_W +: L_SEL_W] = act_l[g][b][rd_addr];
                rd_s[(g*N_BANKS+b)*S_SEL_W +: S_SEL_W] = act_s[g][b][rd_addr];
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int g = 0; g < N_GROUPS; g++)
                for (int b = 0; b < N_BANKS; b++)
                    for (int a = 0; a < KMEM_DEPTH; a++) begin
                        act_l[g][b][a] <= '0;
                        act_s[g][b][a] <= '0;
`ifdef STREAM_SEL_SHADOW_EN
                        sh_l[g][b][a]  <= '0;
                        sh_s[g][b][a]  <= '0;
`endif
                    end
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && !wr_ok;
`ifdef STREAM_SEL_SHADOW_EN
            if (start_fire) begin
                act_l <= sh_l;
                act_s <= sh_s;
            end
            if (wr_ok) begin
                sh_l[cfg_group_i][cfg_bank_i][cfg_addr_i] <= cfg_l_sel_i;
                sh_s[cfg_group_i][cfg_bank_i][cfg_addr_i] <= cfg_s_sel_i;
            end
`else
            if (wr_ok) begin
                act_l[cfg_group_i][cfg_bank_i][cfg_addr_i] <= cfg_l_sel_i;
                act_s[cfg_group_i][cfg_bank_i][cfg_addr_i] <= cfg_s_sel_i;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            addr           <= '0;
            iter           <= '0;
            n_last         <= '0;
            n_iter_m1      <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            l_stream_sel_o <= '0;
            s_stream_sel_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        state          <= RUN;
                        busy_o         <= 1'b1;
                        addr           <= '0;
                        iter           <= '0;
                        n_last         <= n_last_c;
                        n_iter_m1      <= (n_iter_i == '0) ? '0 : n_iter_i - ITER_W'(1);
                        l_stream_sel_o <= rd_l;
                        s_stream_sel_o <= rd_s;
                    end
                end
                RUN: begin
                    if (abort_i || (step_i && addr == n_last && iter == n_iter_m1)) begin
                        state          <= IDLE;
                        busy_o         <= 1'b0;
                        done_o         <= !abort_i;
                        addr           <= '0;
                        iter           <= '0;
                        l_stream_sel_o <= '0;
                        s_stream_sel_o <= '0;
                    end else if (step_i) begin
                        if (addr == n_last)
                            iter <= iter + ITER_W'(1);
                        addr           <= rd_addr;
                        l_stream_sel_o <= rd_l;
                        s_stream_sel_o <= rd_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cur_addr_o = addr;

endmodule

// File: tb/tb_ls_stream_sel_sequencer.sv
// Directed bench for ls_stream_sel_sequencer (KMEM_DEPTH=6 so an out-of-range entry index is drivable).
module tb_ls_stream_sel_sequencer;
    localparam int NG = 4, NB = 4, KD = 6, LW = 2, SW = 2, IW = 8, AW = 3, GW = 2, BW = 2;
`ifdef STREAM_SEL_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_we = 0, cfg_err, start = 0, abort = 0, step = 0, busy, done;
    logic [GW-1:0] cfg_group = '0;
    logic [BW-1:0] cfg_bank = '0;
    logic [AW-1:0] cfg_addr = '0, n_last = '0, cur_addr;
    logic [LW-1:0] cfg_l = '0;
    logic [SW-1:0] cfg_s = '0;
    logic [IW-1:0] n_iter = '0;
    logic [NG*NB*LW-1:0] l_sel;
    logic [NG*NB*SW-1:0] s_sel;
    int n_vec = 0, n_err = 0;

    ls_stream_sel_sequencer #(.N_GROUPS(NG), .N_BANKS(NB), .KMEM_DEPTH(KD),
                              .L_SEL_W(LW), .S_SEL_W(SW), .ITER_W(IW)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_group_i(cfg_group),
        .cfg_bank_i(cfg_bank), .cfg_addr_i(cfg_addr), .cfg_l_sel_i(cfg_l),
        .cfg_s_sel_i(cfg_s), .cfg_err_o(cfg_err), .start_i(start), .abort_i(abort),
        .n_last_i(n_last), .n_iter_i(n_iter), .step_i(step), .busy_o(busy),
        .done_o(done), .cur_addr_o(cur_addr), .l_stream_sel_o(l_sel), .s_stream_sel_o(s_sel));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lsl(input int g, input int b);
        return l_sel[(g*NB+b)*LW +: LW];
    endfunction

    function automatic logic [SW-1:0] ssl(input int g, input int b);
        return s_sel[(g*NB+b)*SW +: SW];
    endfunction

    task automatic wr(input int g, input int b, input int a, input int l, input int s);
        cfg_we = 1; cfg_group = GW'(g); cfg_bank = BW'(b); cfg_addr = AW'(a);
        cfg_l = LW'(l); cfg_s = SW'(s);
        tick();
        cfg_we = 0;
    endtask

    task automatic go(input int last, input int it);
        n_last = AW'(last); n_iter = IW'(it); start = 1;
        tick();
        start = 0;
    endtask

    task automatic stp();
        step = 1;
        tick();
        step = 0;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", cur_addr, 0);
        chk("rst_lsel", l_sel, 0);
        chk("rst_ssel", s_sel, 0);
        rst = 0;
        tick();

        // Basic two-entry sequence on group1/bank2
        wr(1, 2, 0, 3, 1);
        chk("wr0_err", cfg_err, 0);
        wr(1, 2, 1, 2, 0);
        chk("wr1_err", cfg_err, 0);
        go(1, 1);
        chk("st_busy", busy, 1);
        chk("st_addr", cur_addr, 0);
        chk("st_l12", lsl(1, 2), 3);
        chk("st_s12", ssl(1, 2), 1);
        chk("st_l00", lsl(0, 0), 0);
        stp();
        chk("s1_addr", cur_addr, 1);
        chk("s1_l12", lsl(1, 2), 2);
        chk("s1_s12", ssl(1, 2), 0);
        chk("s1_done", done, 0);
        stp();
        chk("s2_done", done, 1);
        chk("s2_busy", busy, 0);
        chk("s2_lsel", l_sel, 0);
        chk("s2_ssel", s_sel, 0);
        tick();
        chk("s2_done_pulse", done, 0);

        // Three iterations of three entries, with a write attempt in RUN
        go(2, 3);
        wr(1, 2, 2, 1, 1);
        chk("run_wr_err", cfg_err, !SHADOW);
        tick();
        chk("run_wr_err_pulse", cfg_err, 0);
        for (int i = 0; i < 9; i++) begin
            chk("loop_addr", cur_addr, i % 3);
            if (i == 2 || i == 5) chk("loop_l12_e2", lsl(1, 2), 0);
            if (i == 3) chk("loop_l12_e0", lsl(1, 2), 3);
            stp();
            chk("loop_done", done, i == 8);
        end
        chk("loop_busy_end", busy, 0);

        // n_iter=0 behaves as a single iteration
        go(2, 0);
        stp();
        stp();
        chk("it0_done2", done, 0);
        stp();
        chk("it0_done3", done, 1);

        // Out-of-range entry index
        wr(1, 2, KD, 1, 0);
        chk("oor_err", cfg_err, 1);
        tick();
        chk("oor_err_pulse", cfg_err, 0);
        go(0, 1);
        chk("oor_l12_e0", lsl(1, 2), 3);
        stp();
        chk("nl0_done", done, 1);

        // n_last beyond the table clamps to the last entry
        go(7, 1);
        for (int i = 0; i < KD - 1; i++) stp();
        chk("clamp_addr", cur_addr, KD - 1);
        chk("clamp_done_early", done, 0);
        stp();
        chk("clamp_done", done, 1);

        // Abort wins over step; abort wins over start in IDLE; step ignored in IDLE
        go(2, 1);
        stp();
        chk("ab_addr1", cur_addr, 1);
        abort = 1; step = 1;
        tick();
        abort = 0; step = 0;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_addr", cur_addr, 0);
        chk("ab_lsel", l_sel, 0);
        tick();
        chk("ab_done_late", done, 0);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("stab_busy", busy, 0);
        stp();
        chk("idle_step_addr", cur_addr, 0);
        chk("idle_step_busy", busy, 0);

        // Asynchronous reset in the middle of a run
        go(5, 1);
        stp(); stp(); stp();
        chk("mr_addr3", cur_addr, 3);
        #1 rst = 1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_addr", cur_addr, 0);
        chk("mr_lsel", l_sel, 0);
        chk("mr_done", done, 0);
        tick();
        rst = 0;
        tick();
        chk("mr_done_after", done, 0);
        go(0, 1);
        chk("mr_tab_clear", lsl(1, 2), 0);
        stp();

`ifdef STREAM_SEL_SHADOW_EN
        wr(1, 2, 0, 3, 1);
        go(0, 2);
        chk("sh_st_l12", lsl(1, 2), 3);
        wr(1, 2, 0, 1, 2);
        chk("sh_wr_err", cfg_err, 0);
        chk("sh_hold_l12", lsl(1, 2), 3);
        stp();
        chk("sh_wrap_l12", lsl(1, 2), 3);
        stp();
        chk("sh_done", done, 1);
        go(0, 1);
        chk("sh_new_l12", lsl(1, 2), 1);
        chk("sh_new_s12", ssl(1, 2), 2);
        stp();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
